voice_allocator: RTL and testbench

Event-driven voice allocator that assigns incoming note-on/note-off events to the `PIPELINE_COUNT` synthesis pipelines whose outputs the mixer sums. It holds per-voice state (active, note, velocity, age) and presents it to the pipelines. It pulses per-voice trigger/release strobes for the envelopes. It steals the oldest voice when all voices are busy.

---
 rtl/voice_allocator_pkg.sv | 21 ++
 rtl/voice_allocator_if.sv | 20 ++
 rtl/voice_allocator_scanner.sv | 75 +++++++
 rtl/voice_allocator.sv | 116 +++++++++++
 tb/tb_voice_allocator.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared voice allocator configuration: MIDI field widths, the per-voice record
// consumed by the synthesis pipelines, and the scan source kinds.
package voice_allocator_pkg;

  localparam int unsigned NOTE_WIDTH     = 7;
  localparam int unsigned VELOCITY_WIDTH = 7;
  localparam int unsigned AGE_WIDTH      = 4;

  typedef struct packed {
    logic                      active;
    logic [NOTE_WIDTH-1:0]     note;
    logic [VELOCITY_WIDTH-1:0] velocity;
  } voice_t;

  typedef enum logic [1:0] {
    SRC_MATCH,
    SRC_FREE,
    SRC_OLDEST
  } src_kind_e;

endpackage

// File: rtl/voice_allocator_if.sv
// Note event valid/ready channel into the voice allocator.
interface voice_allocator_if;
  import voice_allocator_pkg::*;

  logic                      event_valid;
  logic                      event_ready;
  logic                      event_note_on;
  logic [NOTE_WIDTH-1:0]     event_note;
  logic [VELOCITY_WIDTH-1:0] event_velocity;

  modport master (
    output event_valid, event_note_on, event_note, event_velocity,
    input  event_ready
  );

  modport slave (
    input  event_valid, event_note_on, event_note, event_velocity,
    output event_ready
  );
endinterface

// File: rtl/voice_allocator_scanner.sv
// Sequential voice scan: one voice per step, tracking first match, first free
// voice and oldest active voice; presents the resulting commit target.
module voice_scanner
  import voice_allocator_pkg::*;
#(
  parameter int unsigned PIPELINE_COUNT = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     step,
  input  logic [NOTE_WIDTH-1:0]                    note,
  input  logic [PIPELINE_COUNT-1:0]                active,
  input  logic [PIPELINE_COUNT-1:0][NOTE_WIDTH-1:0] notes,
  input  logic [PIPELINE_COUNT-1:0][AGE_WIDTH-1:0]  ages,
  output logic                                     last,
  output logic [$clog2(PIPELINE_COUNT)-1:0]        target,
  output src_kind_e                                kind
);

  localparam int unsigned IDX_W = $clog2(PIPELINE_COUNT);

  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     match_idx;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     oldest_idx;
  logic                 match_found;
  logic                 free_found;
  logic                 oldest_found;
  logic [AGE_WIDTH-1:0] oldest_age;

  assign last = (idx == IDX_W'(PIPELINE_COUNT - 1));

  always_ff @(posedge clk) begin
    if (reset || start) begin
      idx          <= '0;
      match_idx    <= '0;
      free_idx     <= '0;
      oldest_idx   <= '0;
      match_found  <= 1'b0;
      free_found   <= 1'b0;
      oldest_found <= 1'b0;
      oldest_age   <= '0;
    end else if (step) begin
      if (!match_found && active[idx] && (notes[idx] == note)) begin
        match_found <= 1'b1;
        match_idx   <= idx;
      end
      if (!free_found && !active[idx]) begin
        free_found <= 1'b1;
        free_idx   <= idx;
      end
      // strict compare keeps the lowest index on equal ages
      if (active[idx] && (!oldest_found || (ages[idx] > oldest_age))) begin
        oldest_found <= 1'b1;
        oldest_idx   <= idx;
        oldest_age   <= ages[idx];
      end
      idx <= idx + 1'b1;
    end
  end

  always_comb begin
    target = oldest_idx;
    kind   = SRC_OLDEST;
    if (match_found) begin
      target = match_idx;
      kind   = SRC_MATCH;
    end else if (free_found) begin
      target = free_idx;
      kind   = SRC_FREE;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Event-driven voice allocator: latches one note event, scans the voices,
// then commits a trigger, retrigger, steal or release in a single cycle.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int unsigned PIPELINE_COUNT = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  voice_allocator_if.slave                             evt,
  output logic [PIPELINE_COUNT-1:0]                    voice_active,
  output logic [PIPELINE_COUNT-1:0][NOTE_WIDTH-1:0]     voice_note,
  output logic [PIPELINE_COUNT-1:0][VELOCITY_WIDTH-1:0] voice_velocity,
  output logic [PIPELINE_COUNT-1:0]                    voice_trigger,
  output logic [PIPELINE_COUNT-1:0]                    voice_release,
  output logic                                         voice_stolen
);

  localparam int unsigned IDX_W = $clog2(PIPELINE_COUNT);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_e;

  state_e                                      state;
  logic                                        ev_on;
  logic [NOTE_WIDTH-1:0]                       ev_note;
  logic [VELOCITY_WIDTH-1:0]                   ev_velocity;
  voice_t [PIPELINE_COUNT-1:0]                 voice;
  logic [PIPELINE_COUNT-1:0][AGE_WIDTH-1:0]    age;
  logic                                        handshake;
  logic                                        scan_last;
  logic [IDX_W-1:0]                            target;
  src_kind_e                                   kind;

  assign evt.event_ready = (state == IDLE);
  assign handshake       = evt.event_valid && evt.event_ready;

  always_comb begin
    voice_active   = '0;
    voice_note     = '0;
    voice_velocity = '0;
    for (int unsigned i = 0; i < PIPELINE_COUNT; i++) begin
      voice_active[i]   = voice[i].active;
      voice_note[i]     = voice[i].note;
      voice_velocity[i] = voice[i].velocity;
    end
  end

  voice_scanner #(
    .PIPELINE_COUNT(PIPELINE_COUNT)
  ) u_scanner (
    .clk    (clk),
    .reset  (reset),
    .start  (handshake),
    .step   (state == SCAN),
    .note   (ev_note),
    .active (voice_active),
    .notes  (voice_note),
    .ages   (age),
    .last   (scan_last),
    .target (target),
    .kind   (kind)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ev_on         <= 1'b0;
      ev_note       <= '0;
      ev_velocity   <= '0;
      voice         <= '0;
      age           <= '0;
      voice_trigger <= '0;
      voice_release <= '0;
      voice_stolen  <= 1'b0;
    end else begin
      voice_trigger <= '0;
      voice_release <= '0;
      voice_stolen  <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            // zero velocity folds into note-off at latch time
            ev_on       <= evt.event_note_on && (evt.event_velocity != '0);
            ev_note     <= evt.event_note;
            ev_velocity <= evt.event_velocity;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (scan_last) state <= COMMIT;
        end
        COMMIT: begin
          state <= IDLE;
          if (ev_on) begin
            for (int unsigned i = 0; i < PIPELINE_COUNT; i++) begin
              if (IDX_W'(i) == target) begin
                voice[i] <= '{active: 1'b1, note: ev_note, velocity: ev_velocity};
                age[i]   <= '0;
              end else if (voice[i].active && (age[i] != '1)) begin
                age[i] <= age[i] + 1'b1;
              end
            end
            voice_trigger[target] <= 1'b1;
            voice_stolen          <= (kind == SRC_OLDEST);
          end else if (kind == SRC_MATCH) begin
            voice[target].active  <= 1'b0;
            age[target]           <= '0;
            voice_release[target] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator against a rule-level allocation model.
module tb_voice_allocator;
  import voice_allocator_pkg::*;

  localparam int PC = 4;
  typedef logic [PC-1:0][NOTE_WIDTH-1:0]     notes_t;
  typedef logic [PC-1:0][VELOCITY_WIDTH-1:0] vels_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  voice_allocator_if evt();

  logic [PC-1:0] voice_active, voice_trigger, voice_release;
  logic          voice_stolen;
  notes_t        voice_note;
  vels_t         voice_velocity;

  voice_allocator #(.PIPELINE_COUNT(PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .evt            (evt),
    .voice_active   (voice_active),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity),
    .voice_trigger  (voice_trigger),
    .voice_release  (voice_release),
    .voice_stolen   (voice_stolen)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_active[PC];
  int m_note[PC];
  int m_vel[PC];
  int m_age[PC];

  // latest observation and expectation
  logic [PC-1:0] o_trig, o_rel, e_trig, e_rel;
  logic          o_st, e_st;
  int            o_pc, o_np;
  logic [7:1]    o_rdy;

  int fill_notes[4] = '{60, 62, 64, 67};

  function automatic void model_reset();
    for (int i = 0; i < PC; i++) begin
      m_active[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
  endfunction

  function automatic logic [PC-1:0] m_act_v();
    logic [PC-1:0] r;
    for (int i = 0; i < PC; i++) r[i] = (m_active[i] != 0);
    return r;
  endfunction

  function automatic notes_t m_notes_v();
    notes_t r;
    for (int i = 0; i < PC; i++) r[i] = NOTE_WIDTH'(m_note[i]);
    return r;
  endfunction

  function automatic vels_t m_vels_v();
    vels_t r;
    for (int i = 0; i < PC; i++) r[i] = VELOCITY_WIDTH'(m_vel[i]);
    return r;
  endfunction

  task automatic model_event(input bit on, input int note, input int vel,
                             output logic [PC-1:0] trig, output logic [PC-1:0] rel,
                             output logic st);
    int match  = -1;
    int free   = -1;
    int oldest = -1;
    int tgt;
    trig = '0; rel = '0; st = 1'b0;
    for (int i = 0; i < PC; i++) begin
      if (match < 0 && m_active[i] != 0 && m_note[i] == note) match = i;
      if (free < 0 && m_active[i] == 0) free = i;
      if (m_active[i] != 0 && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
    end
    if (on && vel != 0) begin
      tgt = (match >= 0) ? match : (free >= 0) ? free : oldest;
      st  = (match < 0 && free < 0);
      for (int i = 0; i < PC; i++)
        if (i != tgt && m_active[i] != 0) m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
      m_active[tgt] = 1; m_note[tgt] = note; m_vel[tgt] = vel; m_age[tgt] = 0;
      trig[tgt] = 1'b1;
    end else if (match >= 0) begin
      m_active[match] = 0; m_age[match] = 0;
      rel[match] = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    evt.event_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  // One event through the handshake; records pulses and event_ready over the
  // seven cycles following the accepting edge.
  task automatic send_event(input bit on, input int note, input int vel);
    int w = 0;
    @(negedge clk);
    while (evt.event_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (w >= 20) begin
      bad++;
      $display("FAIL send_timeout ready=%b required=1", evt.event_ready);
    end
    evt.event_valid    = 1'b1;
    evt.event_note_on  = on;
    evt.event_note     = NOTE_WIDTH'(note);
    evt.event_velocity = VELOCITY_WIDTH'(vel);
    @(posedge clk);
    #1;
    evt.event_valid    = 1'b0;
    evt.event_note_on  = 1'($urandom);
    evt.event_note     = NOTE_WIDTH'($urandom);
    evt.event_velocity = VELOCITY_WIDTH'($urandom);
    o_trig = '0; o_rel = '0; o_st = 1'b0; o_pc = -1; o_np = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      o_rdy[k] = evt.event_ready;
      if ((voice_trigger | voice_release) != '0 || voice_stolen) begin
        o_np++;
        if (o_pc < 0) o_pc = k;
      end
      o_trig |= voice_trigger;
      o_rel  |= voice_release;
      o_st   |= voice_stolen;
    end
  endtask

  task automatic ev(input bit on, input int note, input int vel);
    model_event(on, note, vel, e_trig, e_rel, e_st);
    send_event(on, note, vel);
  endtask

  task automatic do_fill();
    for (int i = 0; i < 4; i++) ev(1'b1, fill_notes[i], 100);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (evt.event_ready !== 1'b1 || voice_active !== '0 || voice_trigger !== '0 ||
        voice_release !== '0 || voice_stolen !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl ready=%b active=%b trig=%b rel=%b st=%b required 1/0/0/0/0",
               evt.event_ready, voice_active, voice_trigger, voice_release, voice_stolen);
    end
    ev(1'b1, 50, 90);
    do_reset();
    total++;
    if (voice_active !== '0 || voice_note !== '0 || voice_velocity !== '0 || evt.event_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_voices active=%b notes=%h vels=%h ready=%b required all zero, ready 1",
               voice_active, voice_note, voice_velocity, evt.event_ready);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ev(1'b1, fill_notes[i], 100);
      total++;
      if (o_trig !== (4'b0001 << i) || o_st !== 1'b0) begin
        bad++;
        $display("FAIL fill_trig[%0d] trig=%b st=%b required trig=%b st=0", i, o_trig, o_st, 4'b0001 << i);
      end
      total++;
      if (o_pc !== 6 || o_np !== 1) begin
        bad++;
        $display("FAIL fill_latency[%0d] cycle=%0d pulses=%0d required cycle=6 pulses=1", i, o_pc, o_np);
      end
    end
    total++;
    if (voice_active !== 4'b1111 || voice_note !== m_notes_v()) begin
      bad++;
      $display("FAIL fill_state active=%b notes=%h required 1111 notes=%h", voice_active, voice_note, m_notes_v());
    end
  endtask

  task automatic test_steal();
    do_reset();
    do_fill();
    ev(1'b1, 72, 100);
    total++;
    if (o_trig !== 4'b0001 || o_st !== 1'b1 || voice_note[0] !== 7'd72) begin
      bad++;
      $display("FAIL steal_first trig=%b st=%b note0=%0d required 0001/1/72", o_trig, o_st, voice_note[0]);
    end
    ev(1'b1, 73, 80);
    total++;
    if (o_trig !== 4'b0010 || o_trig !== e_trig || o_st !== 1'b1) begin
      bad++;
      $display("FAIL steal_ages trig=%b st=%b required 0010/1", o_trig, o_st);
    end
    // voice 0 would wrap to age 0 after 13 retriggers elsewhere without saturation
    do_reset();
    do_fill();
    repeat (13) ev(1'b1, 67, 100);
    ev(1'b1, 80, 100);
    total++;
    if (o_trig !== 4'b0001 || o_trig !== e_trig || o_st !== 1'b1) begin
      bad++;
      $display("FAIL steal_saturate trig=%b st=%b required 0001/1", o_trig, o_st);
    end
  endtask

  task automatic test_release_reuse();
    do_reset();
    do_fill();
    ev(1'b0, 64, 0);
    total++;
    if (o_rel !== 4'b0100 || o_trig !== '0 || voice_active !== 4'b1011 || o_pc !== 6) begin
      bad++;
      $display("FAIL release rel=%b trig=%b active=%b cycle=%0d required 0100/0000/1011/6",
               o_rel, o_trig, voice_active, o_pc);
    end
    ev(1'b1, 65, 100);
    total++;
    if (o_trig !== 4'b0100 || o_st !== 1'b0 || voice_note[2] !== 7'd65 || voice_active !== 4'b1111) begin
      bad++;
      $display("FAIL reuse trig=%b st=%b note2=%0d active=%b required 0100/0/65/1111",
               o_trig, o_st, voice_note[2], voice_active);
    end
  endtask

  task automatic test_retrigger_edge();
    logic [PC-1:0] s_act;
    notes_t        s_notes;
    vels_t         s_vels;
    do_reset();
    do_fill();
    ev(1'b1, 62, 50);
    total++;
    if (o_trig !== 4'b0010 || o_st !== 1'b0 || voice_velocity[1] !== 7'd50 || voice_velocity !== m_vels_v()) begin
      bad++;
      $display("FAIL retrigger trig=%b st=%b vel1=%0d required 0010/0/50", o_trig, o_st, voice_velocity[1]);
    end
    s_act = voice_active; s_notes = voice_note; s_vels = voice_velocity;
    ev(1'b1, 70, 0);
    total++;
    if (o_np !== 0 || voice_active !== s_act || voice_note !== s_notes || voice_velocity !== s_vels) begin
      bad++;
      $display("FAIL zero_velocity pulses=%0d active=%b required pulses=0 active=%b", o_np, voice_active, s_act);
    end
    ev(1'b0, 99, 55);
    total++;
    if (o_np !== 0 || voice_active !== s_act) begin
      bad++;
      $display("FAIL unmatched_off pulses=%0d active=%b required pulses=0 active=%b", o_np, voice_active, s_act);
    end
  endtask

  task automatic test_throughput();
    int th_note[8];
    int th_vel[8];
    int n_hs = 0;
    int last = -1;
    int tr_cnt = 0, rl_cnt = 0, exp_tr = 0, exp_rl = 0;
    logic [PC-1:0] t, r;
    logic s;
    for (int i = 0; i < 8; i += 2) begin
      th_note[i] = 60 + $urandom_range(0, 3); th_note[i+1] = th_note[i];
      th_vel[i] = $urandom_range(1, 127);     th_vel[i+1] = $urandom_range(0, 127);
    end
    do_reset();
    evt.event_valid    = 1'b1;
    evt.event_note_on  = 1'b1;
    evt.event_note     = NOTE_WIDTH'(th_note[0]);
    evt.event_velocity = VELOCITY_WIDTH'(th_vel[0]);
    for (int c = 0; c < 120 && n_hs < 8; c++) begin
      tr_cnt += $countones(voice_trigger);
      rl_cnt += $countones(voice_release);
      if (evt.event_ready === 1'b1) begin
        if (last >= 0) begin
          total++;
          if (c - last !== 6) begin
            bad++;
            $display("FAIL throughput_gap[%0d] gap=%0d required 6", n_hs, c - last);
          end
        end
        last = c;
        model_event(n_hs % 2 == 0, th_note[n_hs], th_vel[n_hs], t, r, s);
        exp_tr += $countones(t);
        exp_rl += $countones(r);
        n_hs++;
        @(posedge clk);
        #1;
        if (n_hs < 8) begin
          evt.event_note_on  = (n_hs % 2 == 0);
          evt.event_note     = NOTE_WIDTH'(th_note[n_hs]);
          evt.event_velocity = VELOCITY_WIDTH'(th_vel[n_hs]);
        end else begin
          evt.event_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    evt.event_valid = 1'b0;
    total++;
    if (n_hs !== 8) begin
      bad++;
      $display("FAIL throughput_timeout accepted=%0d required 8", n_hs);
    end
    repeat (7) begin
      tr_cnt += $countones(voice_trigger);
      rl_cnt += $countones(voice_release);
      @(negedge clk);
    end
    total++;
    if (tr_cnt !== exp_tr || rl_cnt !== exp_rl || voice_active !== m_act_v()) begin
      bad++;
      $display("FAIL throughput_once triggers=%0d releases=%0d active=%b required %0d/%0d/%b",
               tr_cnt, rl_cnt, voice_active, exp_tr, exp_rl, m_act_v());
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen = 0;
    do_reset();
    do_fill();
    @(negedge clk);
    evt.event_valid    = 1'b1;
    evt.event_note_on  = 1'b1;
    evt.event_note     = 7'd72;
    evt.event_velocity = 7'd100;
    @(posedge clk);
    #1 evt.event_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    model_reset();
    total++;
    if (evt.event_ready !== 1'b1 || voice_active !== '0 || voice_note !== '0 || voice_velocity !== '0 ||
        voice_trigger !== '0 || voice_release !== '0 || voice_stolen !== 1'b0) begin
      bad++;
      $display("FAIL midscan_reset ready=%b active=%b notes=%h trig=%b required ready 1, all zero",
               evt.event_ready, voice_active, voice_note, voice_trigger);
    end
    repeat (8) begin
      @(negedge clk);
      if (voice_trigger !== '0 || voice_stolen !== 1'b0 || voice_active !== '0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL midscan_aborted cycles_with_activity=%0d required 0", seen);
    end
    ev(1'b1, 40, 30);
    total++;
    if (o_trig !== 4'b0001 || voice_note !== m_notes_v() || voice_active !== 4'b0001) begin
      bad++;
      $display("FAIL midscan_recover trig=%b active=%b required 0001/0001", o_trig, voice_active);
    end
  endtask

  task automatic test_random();
    bit on;
    int note, vel, exp_pc, exp_np;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      on   = ($urandom_range(0, 2) != 0);
      note = 60 + $urandom_range(0, 7);
      vel  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
      ev(on, note, vel);
      exp_np = ((e_trig | e_rel) != '0) ? 1 : 0;
      exp_pc = (exp_np != 0) ? 6 : -1;
      total++;
      if (o_trig !== e_trig || o_rel !== e_rel || o_st !== e_st) begin
        bad++;
        $display("FAIL rand_pulses[%0d] trig=%b rel=%b st=%b required %b/%b/%b",
                 n, o_trig, o_rel, o_st, e_trig, e_rel, e_st);
      end
      total++;
      if (voice_active !== m_act_v() || voice_note !== m_notes_v() || voice_velocity !== m_vels_v()) begin
        bad++;
        $display("FAIL rand_state[%0d] active=%b notes=%h vels=%h required %b/%h/%h",
                 n, voice_active, voice_note, voice_velocity, m_act_v(), m_notes_v(), m_vels_v());
      end
      total++;
      if (o_pc !== exp_pc || o_np !== exp_np || o_rdy !== 7'b1100000) begin
        bad++;
        $display("FAIL rand_timing[%0d] cycle=%0d pulses=%0d ready=%b required %0d/%0d/1100000",
                 n, o_pc, o_np, o_rdy, exp_pc, exp_np);
      end
    end
  endtask

  initial begin
    evt.event_valid    = 1'b0;
    evt.event_note_on  = 1'b0;
    evt.event_note     = '0;
    evt.event_velocity = '0;
    model_reset();
    test_reset();
    test_fill();
    test_steal();
    test_release_reuse();
    test_retrigger_edge();
    test_throughput();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
